// File: rtl/jesd204_pattern_gen.sv
// Per-lane transmit soft-PCS stage between the 8b10b encoder and the serializer.
// It inserts K28.5 comma bursts on request and applies a programmable 0..9 bit slip.
module jesd204_pattern_gen #(
  parameter int DATA_PATH_WIDTH   = 4,
  parameter int MIN_PATTERN_WORDS = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            patternalign_en,
  input  logic [DATA_PATH_WIDTH*10-1:0]   in_data,
  input  logic [3:0]                      slip_offset,
  input  logic                            slip_load,
  output logic [DATA_PATH_WIDTH*10-1:0]   out_data,
  output logic                            pattern_active,
  output logic                            slip_error
);

  localparam int DW = DATA_PATH_WIDTH * 10;
  localparam int IW = $clog2(2 * DW);

  localparam logic [9:0] K28_5_P = 10'b1010000011;
  localparam logic [9:0] K28_5_N = 10'b0101111100;

  localparam logic [0:0] ST_DATA    = 1'b0;
  localparam logic [0:0] ST_PATTERN = 1'b1;

  localparam logic [7:0] MIN_CNT    = 8'(MIN_PATTERN_WORDS);
  localparam logic       ODD_WIDTH  = 1'(DATA_PATH_WIDTH % 2);
  localparam logic [9:0] FIRST_NEXT = ODD_WIDTH ? K28_5_P : K28_5_N;

  // Lane i carries the start symbol inverted i times; inverting a K28.5 flips its disparity.
  function automatic logic [DW-1:0] pattern_word(input logic [9:0] start);
    logic [DW-1:0] w;
    logic [9:0]    sym;
    w   = '0;
    sym = start;
    for (int i = 0; i < DATA_PATH_WIDTH; i++) begin
      w[i*10 +: 10] = sym;
      sym           = ~sym;
    end
    return w;
  endfunction

  logic [0:0]    state;
  logic [7:0]    word_cnt;
  logic [9:0]    next_sym;
  logic [3:0]    slip_reg;
  logic [DW-1:0] stage1;
  logic [DW-1:0] prev;
  logic          active1;

  logic [DW-1:0]   first_word;
  logic [DW-1:0]   cont_word;
  logic [9:0]      sym_after;
  logic            exit_ok;
  logic [2*DW-1:0] full;
  logic [IW-1:0]   slip_base;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    first_word = pattern_word(K28_5_N);
    cont_word  = pattern_word(next_sym);
    sym_after  = ODD_WIDTH ? ~next_sym : next_sym;
    exit_ok    = (word_cnt >= MIN_CNT);
    full       = {stage1, prev};
    slip_base  = IW'(DW) - IW'(slip_reg);
  end

  // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_DATA;
      word_cnt <= 8'd0;
      next_sym <= K28_5_N;
      stage1   <= '0;
      active1  <= 1'b0;
    end else begin
      case (state)
        ST_DATA: begin
          if (patternalign_en) begin
            state    <= ST_PATTERN;
            word_cnt <= 8'd1;
            stage1   <= first_word;
            next_sym <= FIRST_NEXT;
            active1  <= 1'b1;
          end else begin
            stage1  <= in_data;
            active1 <= 1'b0;
          end
        end
        ST_PATTERN: begin
          // A dropped request is held off until the minimum burst length has gone out.
          if (!patternalign_en && exit_ok) begin
            state   <= ST_DATA;
            stage1  <= in_data;
            active1 <= 1'b0;
          end else begin
            stage1   <= cont_word;
            next_sym <= sym_after;
            active1  <= 1'b1;
            if (word_cnt != 8'hFF) word_cnt <= word_cnt + 8'd1;
          end
        end
        default: state <= ST_DATA;
      endcase
    end
  end

  // Slip stage: offset k takes the top k bits of the previous word as the low k output bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev           <= '0;
      out_data       <= '0;
      pattern_active <= 1'b0;
      slip_reg       <= 4'd0;
      slip_error     <= 1'b0;
    end else begin
      prev           <= stage1;
      out_data       <= full[slip_base +: DW];
      pattern_active <= active1;
      slip_error     <= slip_load && (slip_offset > 4'd9);
      if (slip_load && (slip_offset <= 4'd9)) slip_reg <= slip_offset;
    end
  end

endmodule
